fill_r: RTL and testbench

Read-fill return stage of the DRAM cache miss path, directly downstream of the fill AR issuer. It pops one outstanding-miss record (TID + address) from the RMiss FIFO per fill. It then accepts that fill's R burst from the CXL controller and assembles the beats into one line. Finally it pushes the line to the fill FIFO (cache data/tag write path) and to the read-response FIFO (return to requester).

---
 rtl/fill_r.sv | 133 +++++++++++++
 tb/tb_fill_r.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fill_r.sv
// fill_r: read-fill return stage of the DRAM cache miss path.
// For each fill it pops one {tid, addr} record from the RMiss FIFO and
// collects that fill's R burst into a single line. It then pushes the line
// to the fill FIFO and to the read-response FIFO.
// Optional build macro FILL_R_ERR_SKIP_EN: when defined, a fill that ends
// with err=1 is pushed only to the response FIFO, never to the fill FIFO.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ID
`define AXI_ID 0
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif

module fill_r #(
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int ID_WIDTH   = `AXI_ID_WIDTH,
  parameter int ID         = `AXI_ID,
  parameter int TID_WIDTH  = `TID_WIDTH,
  parameter int BURST_LEN  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ID_WIDTH-1:0]                    rid_i,
  input  logic [DATA_WIDTH-1:0]                  rdata_i,
  input  logic [1:0]                             rresp_i,
  input  logic                                   rlast_i,
  input  logic                                   rvalid_i,
  output logic                                   rready_o,
  input  logic                                   rmfifo_empty_i,
  output logic                                   rmfifo_rden_o,
  input  logic [TID_WIDTH+ADDR_WIDTH-1:0]        rmfifo_data_i,
  input  logic                                   fillfifo_afull_i,
  output logic                                   fillfifo_wren_o,
  output logic [ADDR_WIDTH+BURST_LEN*DATA_WIDTH-1:0] fillfifo_data_o,
  input  logic                                   rspfifo_afull_i,
  output logic                                   rspfifo_wren_o,
  output logic [TID_WIDTH+BURST_LEN*DATA_WIDTH:0]    rspfifo_data_o
);

  localparam int CNT_W = $clog2(BURST_LEN);

  typedef enum logic [2:0] {S_IDLE, S_POP, S_LOAD, S_BEAT, S_PUSH} state_t;

  state_t                               r_state;
  state_t                               w_next;
  logic [TID_WIDTH-1:0]                 r_tid;
  logic [ADDR_WIDTH-1:0]                r_addr;
  logic [BURST_LEN-1:0][DATA_WIDTH-1:0] r_line;
  logic [CNT_W-1:0]                     r_cnt;
  logic                                 r_err;

  logic w_hs;
  logic w_last_cnt;
  logic w_end;
  logic w_beat_err;
  logic w_unused_ok;

  // rresp_i[0] only distinguishes OKAY from EXOKAY, which is not an error
  assign w_unused_ok = rresp_i[0];

  assign w_hs       = rvalid_i && (r_state == S_BEAT);
  assign w_last_cnt = (r_cnt == CNT_W'(BURST_LEN - 1));
  assign w_end      = w_hs && (rlast_i || w_last_cnt);
  // rlast must land exactly on the final beat; any mismatch poisons the fill
  assign w_beat_err = rresp_i[1] | (rid_i != ID_WIDTH'(ID)) | (rlast_i != w_last_cnt);

  assign fillfifo_data_o = {r_addr, r_line};
  assign rspfifo_data_o  = {r_err, r_tid, r_line};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state decode; space in both output FIFOs is checked before popping
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (!rmfifo_empty_i && !fillfifo_afull_i && !rspfifo_afull_i) w_next = S_POP;
      S_POP:  w_next = S_LOAD;
      S_LOAD: w_next = S_BEAT;
      S_BEAT: if (w_end) w_next = S_PUSH;
      S_PUSH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // outputs decoded from state only
  always_comb begin
    rready_o        = (r_state == S_BEAT);
    rmfifo_rden_o   = (r_state == S_POP);
    rspfifo_wren_o  = (r_state == S_PUSH);
`ifdef FILL_R_ERR_SKIP_EN
    fillfifo_wren_o = (r_state == S_PUSH) && !r_err;
`else
    fillfifo_wren_o = (r_state == S_PUSH);
`endif
  end

  // fill context and line assembly; registers hold still through S_PUSH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tid  <= '0;
      r_addr <= '0;
      r_line <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_tid  <= rmfifo_data_i[ADDR_WIDTH +: TID_WIDTH];
      r_addr <= rmfifo_data_i[ADDR_WIDTH-1:0];
      r_line <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (w_hs) begin
      r_line[r_cnt] <= rdata_i;
      if (!w_end) r_cnt <= r_cnt + 1'b1;
      r_err <= r_err | w_beat_err;
    end
  end

endmodule

// File: tb/tb_fill_r.sv
// Bench for fill_r: RMiss FIFO model, R-channel driver, and a scoreboard of
// expected fill/response pushes checked whenever the DUT pushes.
module tb_fill_r;
  localparam int AW = 32, DW = 64, IDW = 4, TW = 4, BL = 4;
  localparam int FW = AW + BL*DW;
  localparam int RW = 1 + TW + BL*DW;

  logic clk, rst_n;
  logic [IDW-1:0] rid_i;
  logic [DW-1:0] rdata_i;
  logic [1:0] rresp_i;
  logic rlast_i, rvalid_i, rready_o;
  logic rmfifo_empty_i, rmfifo_rden_o;
  logic [TW+AW-1:0] rmfifo_data_i;
  logic fillfifo_afull_i, fillfifo_wren_o;
  logic [FW-1:0] fillfifo_data_o;
  logic rspfifo_afull_i, rspfifo_wren_o;
  logic [RW-1:0] rspfifo_data_o;

  fill_r #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .ID(0),
           .TID_WIDTH(TW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .rmfifo_empty_i(rmfifo_empty_i), .rmfifo_rden_o(rmfifo_rden_o),
    .rmfifo_data_i(rmfifo_data_i), .fillfifo_afull_i(fillfifo_afull_i),
    .fillfifo_wren_o(fillfifo_wren_o), .fillfifo_data_o(fillfifo_data_o),
    .rspfifo_afull_i(rspfifo_afull_i), .rspfifo_wren_o(rspfifo_wren_o),
    .rspfifo_data_o(rspfifo_data_o));

  initial begin clk = 0; forever #5 clk = ~clk; end

  typedef struct {
    logic [TW-1:0]          tid;
    logic [AW-1:0]          addr;
    logic [BL-1:0][DW-1:0]  d;
    logic [BL-1:0][1:0]     resp;
    int                     last;   // beat index carrying rlast; BL = none
    logic [IDW-1:0]         rid;
    bit                     err;    // expected error flag
  } vec_t;

  int n_cmp = 0, n_err = 0, n_rden = 0;
  logic [FW-1:0] q_fill[$];
  logic [RW-1:0] q_rsp[$];

  // RMiss FIFO model: pushes from the stimulus, pops on rden
  logic [TW+AW-1:0] rm_mem[64];
  int rm_pushed = 0, rm_popped = 0;
  assign rmfifo_empty_i = (rm_pushed == rm_popped);
  always @(posedge clk) begin
    if (rmfifo_rden_o) begin
      rmfifo_data_i <= rm_mem[rm_popped];
      rm_popped     <= rm_popped + 1;
    end
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // scoreboard: compare each DUT push against the oldest expectation
  always @(negedge clk) begin
    logic [FW-1:0] ef;
    logic [RW-1:0] er;
    if (rmfifo_rden_o) n_rden++;
    if (rspfifo_wren_o) begin
      if (q_rsp.size() == 0) chk("rsp_unexpected_push", {511'b0, rspfifo_wren_o}, 512'b0);
      else begin er = q_rsp.pop_front(); chk("rsp_data", rspfifo_data_o, er); end
    end
    if (fillfifo_wren_o) begin
      if (q_fill.size() == 0) chk("fill_unexpected_push", {511'b0, fillfifo_wren_o}, 512'b0);
      else begin ef = q_fill.pop_front(); chk("fill_data", fillfifo_data_o, ef); end
    end
  end

  task automatic push_entry(input logic [TW-1:0] tid, input logic [AW-1:0] addr);
    rm_mem[rm_pushed] = {tid, addr};
    rm_pushed++;
  endtask

  task automatic expect_vec(input vec_t v);
    logic [BL-1:0][DW-1:0] line;
    int nb;
    nb = (v.last < BL) ? v.last + 1 : BL;
    for (int i = 0; i < BL; i++) line[i] = (i < nb) ? v.d[i] : '0;
    q_rsp.push_back({v.err, v.tid, line});
`ifdef FILL_R_ERR_SKIP_EN
    if (!v.err) q_fill.push_back({v.addr, line});
`else
    q_fill.push_back({v.addr, line});
`endif
  endtask

  // drive beats 0..nb-1, each held until rready; called at a negedge
  task automatic send_beats(input vec_t v, input int nb, input bit chk_lat);
    int t;
    for (int i = 0; i < nb; i++) begin
      rid_i = v.rid; rdata_i = v.d[i]; rresp_i = v.resp[i];
      rlast_i = (i == v.last); rvalid_i = 1'b1;
      t = 0;
      while (!rready_o && t < 50) begin @(negedge clk); t++; end
      chk("rready_wait", {511'b0, (t < 50)}, 512'b1);
      @(negedge clk);
    end
    rvalid_i = 1'b0; rlast_i = 1'b0;
    if (chk_lat) chk("push_latency", {511'b0, rspfifo_wren_o}, 512'b1);
  endtask

  task automatic drain;
    int t;
    t = 0;
    while ((q_fill.size() + q_rsp.size()) != 0 && t < 20) begin @(negedge clk); t++; end
    chk("drain", q_fill.size() + q_rsp.size(), 0);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int nb;
    nb = (v.last < BL) ? v.last + 1 : BL;
    expect_vec(v);
    push_entry(v.tid, v.addr);
    send_beats(v, nb, 1'b1);
    drain();
  endtask

  vec_t vt[7];
  vec_t v0, vr;

  initial begin
    rst_n = 0; rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = 0; rvalid_i = 0;
    fillfifo_afull_i = 0; rspfifo_afull_i = 0;

    v0    = '{4'd3, 32'h1000, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, '0, 3, 4'd0, 1'b0};
    vt[0] = '{4'd5, 32'h2040, {64'hB3, 64'hB2, 64'hB1, 64'hB0}, {2'b00, 2'b10, 2'b00, 2'b00}, 3, 4'd0, 1'b1};
    vt[1] = '{4'd6, 32'h3000, {64'hC3, 64'hC2, 64'hC1, 64'hC0}, '0, 1, 4'd0, 1'b1};
    vt[2] = '{4'd7, 32'h4000, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, '0, 3, 4'd0, 1'b0};
    vt[3] = '{4'd8, 32'h5000, {64'hE3, 64'hE2, 64'hE1, 64'hE0}, '0, 3, 4'd5, 1'b1};
    vt[4] = '{4'd9, 32'h6000, {64'hF3, 64'hF2, 64'hF1, 64'hF0}, '0, BL, 4'd0, 1'b1};
    vt[5] = '{4'd10, 32'h7000, {64'h1_0003, 64'h1_0002, 64'h1_0001, 64'h1_0000}, {2'b00, 2'b00, 2'b01, 2'b00}, 3, 4'd0, 1'b0};
    vt[6] = '{4'd11, 32'h8000, {64'h2_0003, 64'h2_0002, 64'h2_0001, 64'h2_0000}, {2'b00, 2'b00, 2'b00, 2'b11}, 3, 4'd0, 1'b1};
    vr    = '{4'd12, 32'h9000, {64'h33, 64'h32, 64'h31, 64'h30}, '0, 3, 4'd0, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_outs", {rready_o, rmfifo_rden_o, fillfifo_wren_o, rspfifo_wren_o}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_fill_data", fillfifo_data_o, 0);
    chk("rst_rsp_data", rspfifo_data_o, 0);
    chk("idle_rready", {511'b0, rready_o}, 0);

    // rvalid raised before any entry: must wait until 2 cycles after rden
    rid_i = '0; rdata_i = v0.d[0]; rresp_i = '0; rlast_i = 0; rvalid_i = 1;
    repeat (3) begin @(negedge clk); chk("early_rvalid_rready", {511'b0, rready_o}, 0); end
    expect_vec(v0);
    push_entry(v0.tid, v0.addr);
    begin
      int t;
      t = 0;
      while (!rmfifo_rden_o && t < 10) begin @(negedge clk); t++; end
      chk("rden_seen", {511'b0, rmfifo_rden_o}, 512'b1);
    end
    @(negedge clk); chk("rready_load", {511'b0, rready_o}, 0);
    chk("rden_one_cycle", {511'b0, rmfifo_rden_o}, 0);
    @(negedge clk); chk("rready_beat", {511'b0, rready_o}, 512'b1);
    send_beats(v0, BL, 1'b1);
    drain();

    // table-driven fills: errors, early rlast, missing rlast, bad rid
    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // afull blocks the pop; releasing it pops on the next cycle
    fillfifo_afull_i = 1;
    expect_vec(v0);
    push_entry(v0.tid, v0.addr);
    begin
      int cnt;
      cnt = 0;
      repeat (10) begin @(negedge clk); if (rmfifo_rden_o) cnt++; end
      chk("afull_no_rden", cnt, 0);
    end
    fillfifo_afull_i = 0;
    @(negedge clk); chk("afull_release_rden", {511'b0, rmfifo_rden_o}, 512'b1);
    send_beats(v0, BL, 1'b1);
    drain();

    // async reset mid-burst after 2 beats: nothing pushed, entry lost
    push_entry(vr.tid, vr.addr);
    send_beats(vr, 2, 1'b0);
    #2 rst_n = 0;
    #1;
    chk("midrst_ctrl", {rready_o, rmfifo_rden_o, fillfifo_wren_o, rspfifo_wren_o}, 0);
    chk("midrst_fill_data", fillfifo_data_o, 0);
    chk("midrst_rsp_data", rspfifo_data_o, 0);
    @(negedge clk); rst_n = 1;
    repeat (3) @(negedge clk);
    chk("midrst_no_push", q_fill.size() + q_rsp.size(), 0);
    run_vec(vt[2]);

    chk("rden_count", n_rden, rm_pushed);
    chk("rm_all_popped", rm_popped, rm_pushed);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  // absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
